// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receive/transmit blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } rx_state_t;

  // Width of the per-bit sample counter for a given oversampling ratio.
  function automatic int samp_w(input int os);
    return (os > 1) ? $clog2(os) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every BAUD_DIV clk cycles.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 27
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, oversampling FSM and rdrf/rdrf_clr host handshake.
// Handshake: rdrf rises on the edge after a frame completes; a one-cycle rdrf_clr pulse drops
// rdrf and OE; a completion while rdrf=1 and rdrf_clr=0 keeps the old frame and raises OE.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      OVERSAMPLE = 16,
  parameter int      BAUD_DIV   = 27
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 RxD,
  input  logic                 rdrf_clr,
  output logic                 rdrf,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 FE,
  output logic                 PE,
  output logic                 OE,
  output logic [2:0]           dbg_state
);

  localparam int             SW        = samp_w(OVERSAMPLE);
  localparam logic [SW-1:0]  MID_START = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]  MID_BIT   = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);
  localparam bit             HAS_PAR   = (PARITY != PAR_NONE);
  localparam logic           ODD_PAR   = (PARITY == PAR_ODD);

  logic                 r_sync1, r_sync2;
  rx_state_t            r_state, w_state_n;
  logic [SW-1:0]        r_samp, w_samp_n;
  logic [3:0]           r_bitcnt, w_bitcnt_n;
  logic                 r_stopcnt, w_stopcnt_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_pe_acc, w_pe_n;
  logic                 r_fe_acc, w_fe_n;
  logic                 w_done, w_tick, w_rxs, w_mid;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk  (clk),
    .clr  (clr),
    .tick (w_tick)
  );

  assign w_rxs     = r_sync2;
  assign w_mid     = (r_samp == MID_BIT);
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= IDLE;
      r_samp    <= '0;
      r_bitcnt  <= '0;
      r_stopcnt <= 1'b0;
      r_shift   <= '0;
      r_pe_acc  <= 1'b0;
      r_fe_acc  <= 1'b0;
    end else begin
      r_sync1   <= RxD;
      r_sync2   <= r_sync1;
      r_state   <= w_state_n;
      r_samp    <= w_samp_n;
      r_bitcnt  <= w_bitcnt_n;
      r_stopcnt <= w_stopcnt_n;
      r_shift   <= w_shift_n;
      r_pe_acc  <= w_pe_n;
      r_fe_acc  <= w_fe_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_samp_n    = r_samp;
    w_bitcnt_n  = r_bitcnt;
    w_stopcnt_n = r_stopcnt;
    w_shift_n   = r_shift;
    w_pe_n      = r_pe_acc;
    w_fe_n      = r_fe_acc;
    w_done      = 1'b0;
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            w_state_n = START;
            w_samp_n  = '0;
          end
        end
        START: begin
          // A start bit that is high again at its centre was a glitch.
          if (r_samp == MID_START) begin
            if (w_rxs) begin
              w_state_n = IDLE;
            end else begin
              w_state_n  = DATA;
              w_samp_n   = '0;
              w_bitcnt_n = '0;
              w_pe_n     = 1'b0;
              w_fe_n     = 1'b0;
            end
          end else begin
            w_samp_n = r_samp + 1'b1;
          end
        end
        DATA: begin
          if (w_mid) begin
            w_samp_n   = '0;
            w_shift_n  = {w_rxs, r_shift[DATA_BITS-1:1]};
            w_bitcnt_n = r_bitcnt + 1'b1;
            if (r_bitcnt == LAST_DATA) begin
              w_stopcnt_n = 1'b0;
              w_state_n   = HAS_PAR ? uart_pkg::PARITY : STOP;
            end
          end else begin
            w_samp_n = r_samp + 1'b1;
          end
        end
        uart_pkg::PARITY: begin
          if (w_mid) begin
            w_samp_n  = '0;
            w_pe_n    = ((^r_shift) ^ w_rxs) != ODD_PAR;
            w_state_n = STOP;
          end else begin
            w_samp_n = r_samp + 1'b1;
          end
        end
        STOP: begin
          if (w_mid) begin
            w_samp_n = '0;
            w_fe_n   = r_fe_acc | ~w_rxs;
            if (r_stopcnt == LAST_STOP) begin
              w_done    = 1'b1;
              w_state_n = (r_fe_acc | ~w_rxs) ? BRK : IDLE;
            end else begin
              w_stopcnt_n = r_stopcnt + 1'b1;
            end
          end else begin
            w_samp_n = r_samp + 1'b1;
          end
        end
        BRK: begin
          if (w_rxs) w_state_n = IDLE;
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rdrf    <= 1'b0;
      rx_data <= '0;
      FE      <= 1'b0;
      PE      <= 1'b0;
      OE      <= 1'b0;
    end else if (w_done) begin
      if (!rdrf || rdrf_clr) begin
        rdrf    <= 1'b1;
        rx_data <= r_shift;
        FE      <= w_fe_n;
        PE      <= HAS_PAR ? r_pe_acc : 1'b0;
        if (rdrf_clr) OE <= 1'b0;
      end else begin
        OE <= 1'b1;
      end
    end else if (rdrf_clr) begin
      rdrf <= 1'b0;
      OE   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 receiver and an even-parity receiver, 64 clk per bit.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int BIT_CYC = 64;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       rxd = 1'b1;
  logic       rxd_e = 1'b1;
  logic       rdrf_clr = 1'b0;
  logic       rdrf_clr_e = 1'b0;
  logic       rdrf, rdrf_e;
  logic [7:0] rx_data, rx_data_e;
  logic       fe, pe, oe, fe_e, pe_e, oe_e;
  logic [2:0] dbg_state, dbg_state_e;

  int checks = 0;
  int failures = 0;
  int rdrf_rises = 0;
  logic rdrf_q = 1'b0;

  uart_rx_param #(
    .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .OVERSAMPLE(16), .BAUD_DIV(4)
  ) dut (
    .clk(clk), .clr(clr), .RxD(rxd), .rdrf_clr(rdrf_clr),
    .rdrf(rdrf), .rx_data(rx_data), .FE(fe), .PE(pe), .OE(oe), .dbg_state(dbg_state)
  );

  uart_rx_param #(
    .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .OVERSAMPLE(16), .BAUD_DIV(4)
  ) dut_e (
    .clk(clk), .clr(clr), .RxD(rxd_e), .rdrf_clr(rdrf_clr_e),
    .rdrf(rdrf_e), .rx_data(rx_data_e), .FE(fe_e), .PE(pe_e), .OE(oe_e),
    .dbg_state(dbg_state_e)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdrf_q <= rdrf;
    if (rdrf && !rdrf_q) rdrf_rises <= rdrf_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drivers: bits are sent LSB first, one bit period each
  task automatic send_bits(input logic [15:0] bits, input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      if (sel) rxd_e = bits[i];
      else     rxd   = bits[i];
      repeat (BIT_CYC) @(negedge clk);
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic stopb);
    send_bits({6'b0, stopb, d, 1'b0}, 10, 1'b0);
  endtask

  task automatic send8p(input logic [7:0] d, input logic par);
    send_bits({5'b0, 1'b1, par, d, 1'b0}, 11, 1'b1);
  endtask

  task automatic pulse_clr;
    rdrf_clr = 1'b1;
    @(negedge clk);
    rdrf_clr = 1'b0;
  endtask

  task automatic pulse_clr_e;
    rdrf_clr_e = 1'b1;
    @(negedge clk);
    rdrf_clr_e = 1'b0;
  endtask

  initial begin
    bit found;
    // reset
    repeat (3) @(negedge clk);
    clr = 1'b0;
    check("rst_rdrf", rdrf, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_fe", fe, 1'b0);
    check("rst_pe", pe, 1'b0);
    check("rst_oe", oe, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    check("rst_rdrf_e", rdrf_e, 1'b0);
    repeat (20) @(negedge clk);

    // 8N1 0xA5
    send8(8'hA5, 1'b1);
    check("a5_rdrf", rdrf, 1'b1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_fe", fe, 1'b0);
    check("a5_pe", pe, 1'b0);
    check("a5_oe", oe, 1'b0);
    pulse_clr();
    check("a5_clr_rdrf", rdrf, 1'b0);

    // start-bit glitch
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_rdrf", rdrf, 1'b0);
    check("glitch_state", dbg_state, 3'd0);
    send8(8'h3C, 1'b1);
    check("after_glitch_rdrf", rdrf, 1'b1);
    check("after_glitch_data", rx_data, 8'h3C);
    check("after_glitch_fe", fe, 1'b0);
    pulse_clr();
    repeat (20) @(negedge clk);

    // framing error followed by a long break
    rdrf_rises = 0;
    send8(8'h00, 1'b0);
    rxd = 1'b0;
    repeat (200) @(negedge clk);
    check("brk_data", rx_data, 8'h00);
    check("brk_fe", fe, 1'b1);
    check("brk_rises", rdrf_rises, 1);
    check("brk_state", dbg_state, 3'd5);
    rxd = 1'b1;
    repeat (BIT_CYC) @(negedge clk);
    check("brk_exit_state", dbg_state, 3'd0);
    pulse_clr();
    send8(8'h3C, 1'b1);
    check("post_brk_rdrf", rdrf, 1'b1);
    check("post_brk_data", rx_data, 8'h3C);
    check("post_brk_fe", fe, 1'b0);
    pulse_clr();
    repeat (20) @(negedge clk);

    // even parity: 0x07 has three ones, so parity bit 1 is correct
    send8p(8'h07, 1'b0);
    check("par_bad_rdrf", rdrf_e, 1'b1);
    check("par_bad_pe", pe_e, 1'b1);
    check("par_bad_data", rx_data_e, 8'h07);
    pulse_clr_e();
    repeat (20) @(negedge clk);
    send8p(8'h07, 1'b1);
    check("par_good_pe", pe_e, 1'b0);
    check("par_good_data", rx_data_e, 8'h07);
    check("par_good_fe", fe_e, 1'b0);

    // overrun
    send8(8'h11, 1'b1);
    repeat (10) @(negedge clk);
    send8(8'h22, 1'b1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_oe", oe, 1'b1);
    check("ovr_rdrf", rdrf, 1'b1);
    pulse_clr();
    check("ovr_clr_rdrf", rdrf, 1'b0);
    check("ovr_clr_oe", oe, 1'b0);
    send8(8'h33, 1'b1);
    check("ovr_33_data", rx_data, 8'h33);

    // completion coincident with rdrf_clr: completion is 63 cycles after STOP is first seen
    found = 1'b0;
    fork
      send8(8'h44, 1'b1);
      begin
        for (int i = 0; i < 1000 && !found; i++) begin
          @(negedge clk);
          if (dbg_state == 3'd4) found = 1'b1;
        end
        if (found) begin
          repeat (63) @(negedge clk);
          pulse_clr();
        end
      end
    join
    check("coinc_stop_seen", found, 1'b1);
    check("coinc_data", rx_data, 8'h44);
    check("coinc_oe", oe, 1'b0);
    check("coinc_rdrf", rdrf, 1'b1);

    // reset during data bit 3 of 0x5A (line returns idle when reset hits)
    send_bits(16'h0004, 4, 1'b0);
    rxd = 1'b1;
    repeat (BIT_CYC / 2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("midrst_rdrf", rdrf, 1'b0);
    check("midrst_data", rx_data, 8'h00);
    check("midrst_fe", fe, 1'b0);
    check("midrst_pe", pe, 1'b0);
    check("midrst_oe", oe, 1'b0);
    check("midrst_state", dbg_state, 3'd0);
    repeat (200) @(negedge clk);
    check("midrst_idle_rdrf", rdrf, 1'b0);
    send8(8'h5A, 1'b1);
    check("5a_rdrf", rdrf, 1'b1);
    check("5a_data", rx_data, 8'h5A);
    check("5a_fe", fe, 1'b0);
    check("5a_pe", pe, 1'b0);
    check("5a_oe", oe, 1'b0);

    // report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
